// File: rtl/strontium_div_pkg.sv
// Shared definitions for the sequential divider.
// Holds the FSM state encoding, the default operand width and the
// constants produced for a divide-by-zero result.
package strontium_div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    // Divide-by-zero result: flag set, quotient all ones, remainder = dividend
    localparam logic                 DIV0_FLAG     = 1'b1;
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division iteration.
// Ports:
//   rem, quo      current partial remainder and quotient/dividend shift register
//   divisor_mag   divisor magnitude
//   rem_next      partial remainder after this step
//   quo_next      quotient register after this step (new bit shifted in at bit 0)
module div_step
    import strontium_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0]   rem_sh;
    logic             trial_neg;
    logic             unused_trial_msb;
    logic [WIDTH-1:0] trial_rem;

    // Shift the next dividend bit into the remainder; keep the carry-out bit
    assign rem_sh = {rem, quo[WIDTH-1]};

    // A non-negative trial never exceeds the divisor, so bit WIDTH is always zero then
    assign {trial_neg, unused_trial_msb, trial_rem} =
        {1'b0, rem_sh} - {2'b00, divisor_mag};

    assign rem_next = trial_neg ? rem_sh[WIDTH-1:0] : trial_rem;
    assign quo_next = {quo[WIDTH-2:0], ~trial_neg};

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU.
// Accepts one operand pair over valid/ready, returns quotient (LO) and
// remainder (HI) a fixed WIDTH+2 cycles after the accept edge.
// Build option: SEQ_DIV_SIGNED_EN -- when defined, is_signed selects two's
// complement division; when undefined every division is unsigned and no
// sign tracking or negation logic is built.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   flush                  synchronous abort, wins over in_valid
//   in_valid / in_ready    operand handshake (in_ready high only in IDLE)
//   dividend, divisor      operands
//   is_signed              1 = DIV, 0 = DIVU
//   out_valid / out_ready  result handshake, result held until accepted
//   quotient, remainder    result
//   div_zero               divisor of the current result was zero
module seq_divider
    import strontium_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    div_state_e       state;
    div_state_e       state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor_mag;
    logic             dz_q;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] dividend_mag_c;
    logic [WIDTH-1:0] divisor_mag_c;
    logic [WIDTH-1:0] quo_fixed_c;
    logic [WIDTH-1:0] rem_fixed_c;
    logic             accept_c;

    assign accept_c = (state == ST_IDLE) && in_valid && !flush;

`ifdef SEQ_DIV_SIGNED_EN
    logic dividend_neg_c;
    logic divisor_neg_c;
    logic neg_quo;
    logic neg_rem;

    // Magnitudes are taken at accept time; -2**(WIDTH-1) maps onto itself as unsigned
    assign dividend_neg_c = is_signed & dividend[WIDTH-1];
    assign divisor_neg_c  = is_signed & divisor[WIDTH-1];
    assign dividend_mag_c = dividend_neg_c ? (~dividend + WIDTH'(1)) : dividend;
    assign divisor_mag_c  = divisor_neg_c  ? (~divisor  + WIDTH'(1)) : divisor;

    // Quotient negated on differing signs, remainder follows the dividend sign
    assign quo_fixed_c = neg_quo ? (~quo + WIDTH'(1)) : quo;
    assign rem_fixed_c = neg_rem ? (~rem + WIDTH'(1)) : rem;

    // Sign bookkeeping captured with the operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
        end else if (accept_c) begin
            neg_quo <= dividend_neg_c ^ divisor_neg_c;
            neg_rem <= dividend_neg_c;
        end
    end
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed;
    assign dividend_mag_c   = dividend;
    assign divisor_mag_c    = divisor;
    assign quo_fixed_c      = quo;
    assign rem_fixed_c      = rem;
`endif

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem        (rem),
        .quo        (quo),
        .divisor_mag(divisor_mag),
        .rem_next   (rem_step),
        .quo_next   (quo_step)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (in_valid) state_next = ST_CALC;
            ST_CALC: if (cnt == CNT_W'(WIDTH - 1)) state_next = ST_FIX;
            ST_FIX:  state_next = ST_DONE;
            ST_DONE: if (out_valid && out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (flush) begin
            state_next = ST_IDLE;
        end
    end

    // Iteration datapath: load on accept, one restoring step per CALC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            divisor_mag <= '0;
            dz_q        <= 1'b0;
        end else if (accept_c) begin
            cnt         <= '0;
            rem         <= '0;
            quo         <= dividend_mag_c;
            divisor_mag <= divisor_mag_c;
            dz_q        <= (divisor == '0) ? DIV0_FLAG : 1'b0;
        end else if (state == ST_CALC) begin
            cnt <= cnt + CNT_W'(1);
            rem <= rem_step;
            quo <= quo_step;
        end
    end

    // Registered outputs. out_valid rises one cycle into DONE, giving WIDTH+2 latency.
    // With a zero divisor the remainder already equals |dividend|, so the sign fix
    // restores the original dividend; only the quotient needs forcing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            in_ready  <= (state_next == ST_IDLE);
            out_valid <= (state == ST_DONE) && !flush && !(out_valid && out_ready);
            if ((state == ST_FIX) && !flush) begin
                quotient  <= dz_q ? {WIDTH{1'b1}} : quo_fixed_c;
                remainder <= rem_fixed_c;
                div_zero  <= dz_q;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: scoreboard of expected results,
// one task per scenario. Expectations follow the build option SEQ_DIV_SIGNED_EN.
module tb_seq_divider;

    localparam int unsigned W   = 32;
    localparam int          LAT = 34;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         is_signed;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t sb[$];

    seq_divider dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dividend (dividend),
        .divisor  (divisor),
        .is_signed(is_signed),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient (quotient),
        .remainder(remainder),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit signed_build();
`ifdef SEQ_DIV_SIGNED_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Reference model using the simulator's own division operators
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        logic na, nb;
        logic [W-1:0] ma, mb;
        if (b == '0) begin
            e.q = '1; e.r = a; e.dz = 1'b1;
            return e;
        end
        na = signed_build() & s & a[W-1];
        nb = signed_build() & s & b[W-1];
        ma = na ? W'(-a) : a;
        mb = nb ? W'(-b) : b;
        e.q  = ma / mb;
        e.r  = ma % mb;
        e.dz = 1'b0;
        if (na ^ nb) e.q = W'(-e.q);
        if (na)      e.r = W'(-e.r);
        return e;
    endfunction

    // Present a request until accepted; returns after the accept edge (+1)
    task automatic send_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        bit rdy;
        bit ok;
        ok = 1'b0;
        dividend = a; divisor = b; is_signed = s; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) begin ok = 1'b1; break; end
        end
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: request %h/%h never accepted", a, b);
        end
    endtask

    // Count edges from the accept edge until out_valid; -1 on timeout
    task automatic wait_out(output int lat);
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = n; break; end
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0; is_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (quotient !== '0) begin errors++; $display("FAIL reset_quotient: got %h want 0", quotient); end
        checks++; if (remainder !== '0) begin errors++; $display("FAIL reset_remainder: got %h want 0", remainder); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero: got %b want 0", div_zero); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Table of divisions checked against the scoreboard, latency included
    task automatic test_unsigned();
        logic [W-1:0] ta[6];
        logic [W-1:0] tb[6];
        int lat;
        exp_t e;
        ta[0] = 32'd100;        tb[0] = 32'd7;
        ta[1] = 32'hFFFF_FFFF;  tb[1] = 32'd1;
        ta[2] = 32'd5;          tb[2] = 32'd9;
        ta[3] = 32'hFFFF_FFFF;  tb[3] = 32'hFFFF_FFFF;
        ta[4] = $urandom;       tb[4] = $urandom_range(1, 1000);
        ta[5] = $urandom;       tb[5] = $urandom;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                e.q = 32'd14; e.r = 32'd2; e.dz = 1'b0;
                sb.push_back(e);
            end else begin
                sb.push_back(model(ta[i], tb[i], 1'b0));
            end
            send_req(ta[i], tb[i], 1'b0);
            wait_out(lat);
            e = sb.pop_front();
            checks++;
            if (lat != LAT) begin errors++; $display("FAIL divu_latency[%0d]: got %0d want %0d", i, lat, LAT); end
            checks++;
            if (quotient !== e.q || remainder !== e.r || div_zero !== e.dz) begin
                errors++;
                $display("FAIL divu_result[%0d] %h/%h: got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                         i, ta[i], tb[i], quotient, remainder, div_zero, e.q, e.r, e.dz);
            end
            release_out();
        end
    endtask

    // Sign handling and the most-negative / -1 wrap case
    task automatic test_signed();
        logic [W-1:0] ta[5];
        logic [W-1:0] tb[5];
        logic         ts[5];
        exp_t         te[5];
        bit sg;
        int lat;
        exp_t e;
        sg = signed_build();
        ta[0] = 32'hFFFF_FFF9; tb[0] = 32'd2;          ts[0] = 1'b1;
        ta[1] = 32'd7;         tb[1] = 32'hFFFF_FFFE;  ts[1] = 1'b1;
        ta[2] = 32'h8000_0000; tb[2] = 32'hFFFF_FFFF;  ts[2] = 1'b1;
        ta[3] = 32'h8000_0000; tb[3] = 32'hFFFF_FFFF;  ts[3] = 1'b0;
        ta[4] = 32'hFFFF_FF9C; tb[4] = 32'hFFFF_FFF9;  ts[4] = 1'b1;
        te[0] = sg ? '{q: 32'hFFFF_FFFD, r: 32'hFFFF_FFFF, dz: 1'b0}
                   : '{q: 32'h7FFF_FFFC, r: 32'd1,         dz: 1'b0};
        te[1] = sg ? '{q: 32'hFFFF_FFFD, r: 32'd1, dz: 1'b0}
                   : '{q: 32'd0,         r: 32'd7, dz: 1'b0};
        te[2] = sg ? '{q: 32'h8000_0000, r: 32'd0,         dz: 1'b0}
                   : '{q: 32'd0,         r: 32'h8000_0000, dz: 1'b0};
        te[3] = '{q: 32'd0, r: 32'h8000_0000, dz: 1'b0};
        te[4] = sg ? '{q: 32'd14, r: 32'hFFFF_FFFE, dz: 1'b0}
                   : '{q: 32'd0,  r: 32'hFFFF_FF9C, dz: 1'b0};
        for (int i = 0; i < 5; i++) begin
            sb.push_back(te[i]);
            send_req(ta[i], tb[i], ts[i]);
            wait_out(lat);
            e = sb.pop_front();
            checks++;
            if (lat != LAT) begin errors++; $display("FAIL div_latency[%0d]: got %0d want %0d", i, lat, LAT); end
            checks++;
            if (quotient !== e.q || remainder !== e.r || div_zero !== e.dz) begin
                errors++;
                $display("FAIL div_result[%0d] %h/%h s=%b: got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                         i, ta[i], tb[i], ts[i], quotient, remainder, div_zero, e.q, e.r, e.dz);
            end
            release_out();
        end
    endtask

    // Zero divisor in both modes, then a normal divide clears the flag
    task automatic test_div_zero();
        logic [W-1:0] ta[3];
        logic [W-1:0] tb[3];
        logic         ts[3];
        int lat;
        exp_t e;
        ta[0] = 32'd12345;     tb[0] = 32'd0; ts[0] = 1'b0;
        ta[1] = 32'hFFFF_FFFB; tb[1] = 32'd0; ts[1] = 1'b1;
        ta[2] = 32'd9;         tb[2] = 32'd3; ts[2] = 1'b0;
        sb.push_back('{q: 32'hFFFF_FFFF, r: 32'd12345,     dz: 1'b1});
        sb.push_back('{q: 32'hFFFF_FFFF, r: 32'hFFFF_FFFB, dz: 1'b1});
        sb.push_back('{q: 32'd3,         r: 32'd0,         dz: 1'b0});
        for (int i = 0; i < 3; i++) begin
            send_req(ta[i], tb[i], ts[i]);
            wait_out(lat);
            e = sb.pop_front();
            checks++;
            if (lat != LAT) begin errors++; $display("FAIL dz_latency[%0d]: got %0d want %0d", i, lat, LAT); end
            checks++;
            if (quotient !== e.q || remainder !== e.r || div_zero !== e.dz) begin
                errors++;
                $display("FAIL dz_result[%0d] %h/%h: got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                         i, ta[i], tb[i], quotient, remainder, div_zero, e.q, e.r, e.dz);
            end
            release_out();
        end
    endtask

    // Abort mid-calculation, flush colliding with a request, then recovery
    task automatic test_flush();
        bit seen;
        int lat;
        exp_t e;
        send_req(32'd1000, 32'd3, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL flush_no_result: got out_valid=1 want never"); end
        // Flush in the same cycle as in_valid: request must not be taken
        dividend = 32'd50; divisor = 32'd5; is_signed = 1'b0;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_vs_valid: got in_ready=%b want 1", in_ready); end
        sb.push_back('{q: 32'd3, r: 32'd0, dz: 1'b0});
        send_req(32'd9, 32'd3, 1'b0);
        wait_out(lat);
        e = sb.pop_front();
        checks++;
        if (lat != LAT || quotient !== e.q || remainder !== e.r) begin
            errors++;
            $display("FAIL flush_recover: got lat=%0d q=%h r=%h want lat=%0d q=%h r=%h",
                     lat, quotient, remainder, LAT, e.q, e.r);
        end
        release_out();
    endtask

    // Consumer stalls: result and handshake signals stay put
    task automatic test_stall();
        int lat;
        exp_t e;
        sb.push_back(model(32'hDEAD_BEEF, 32'h0000_1234, 1'b0));
        send_req(32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
        wait_out(lat);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== e.q || remainder !== e.r) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b rdy=%b q=%h r=%h want v=1 rdy=0 q=%h r=%h",
                         i, out_valid, in_ready, quotient, remainder, e.q, e.r);
            end
            @(posedge clk); #1;
        end
        release_out();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== e.q) begin
            errors++;
            $display("FAIL stall_release: got v=%b rdy=%b q=%h want v=0 rdy=1 q=%h",
                     out_valid, in_ready, quotient, e.q);
        end
    endtask

    // Asynchronous reset in the middle of a calculation
    task automatic test_reset_mid();
        send_req(32'd50, 32'd5, 1'b0);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== '0 || remainder !== '0 || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got rdy=%b v=%b q=%h r=%h dz=%b want 1 0 0 0 0",
                     in_ready, out_valid, quotient, remainder, div_zero);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Consecutive random requests, each issued as soon as the previous is accepted
    task automatic test_back_to_back();
        logic [W-1:0] a, b;
        logic s;
        int lat;
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i % 2 == 0) ? W'($urandom_range(1, 300)) : W'($urandom);
            s = 1'($urandom_range(0, 1));
            sb.push_back(model(a, b, s));
            send_req(a, b, s);
            wait_out(lat);
            e = sb.pop_front();
            checks++;
            if (lat != LAT || quotient !== e.q || remainder !== e.r || div_zero !== e.dz) begin
                errors++;
                $display("FAIL b2b[%0d] %h/%h s=%b: got lat=%0d q=%h r=%h dz=%b want lat=%0d q=%h r=%h dz=%b",
                         i, a, b, s, lat, quotient, remainder, div_zero, LAT, e.q, e.r, e.dz);
            end
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_flush();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d entries want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
